// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Two-requester arbiter and sequencer in front of a single-port word data
//   memory. The core load/store unit (core_*) and a DMA/debug master (dma_*)
//   share the memory. Every access runs IDLE -> ACCESS -> DONE, so an access
//   takes at least 3 cycles. The range and alignment check is done on the
//   latched address before the memory is touched.
//
//   Compile-time option:
//     ARB_FIXED_PRIO_EN  defined   : core always wins simultaneous requests.
//                                    The DMA can starve while core_req stays high.
//                        undefined : round-robin on simultaneous requests (default).
//
//   Handshake: a requester raises *_req with its command fields stable and
//   holds them until its *_ack. Requests are sampled only in IDLE. *_ack is a
//   registered one-cycle pulse in DONE. *_err is valid only with *_ack.
//   *_rdata is valid with *_ack and holds its value until that requester's
//   next completion. A req still high in the IDLE after DONE counts as a new
//   request.
//
//   state_dbg exposes the FSM state (0=IDLE, 1=ACCESS, 2=DONE).

module data_mem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  // core load/store unit
  input  logic              core_req,
  input  logic              core_we,
  input  logic [31:0]       core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_ack,
  output logic              core_err,
  output logic [DATA_W-1:0] core_rdata,
  // DMA / debug master
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [31:0]       dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic              dma_err,
  output logic [DATA_W-1:0] dma_rdata,
  // memory side
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  // status
  output logic              busy,
  output logic              grant_id,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t            state;
  logic              lat_we;
  logic [31:0]       lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_id;      // 0 = core, 1 = dma
  logic              last_grant;  // owner of the most recent grant

  logic              pick_dma;
  logic              sel_we;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              addr_err;

  // Winner selection. A lone request always wins. On a tie the requester that
  // did not get the last grant wins, unless fixed priority is built in.
  always_comb begin
    pick_dma = 1'b0;
    if (core_req && dma_req) begin
`ifdef ARB_FIXED_PRIO_EN
      pick_dma = 1'b0;
`else
      pick_dma = ~last_grant;
`endif
    end else begin
      pick_dma = dma_req;
    end
  end

  // Command fields of the selected requester, latched on IDLE -> ACCESS.
  always_comb begin
    sel_we    = core_we;
    sel_addr  = core_addr;
    sel_wdata = core_wdata;
    if (pick_dma) begin
      sel_we    = dma_we;
      sel_addr  = dma_addr;
      sel_wdata = dma_wdata;
    end
  end

  // The address must be word aligned and must fall inside the 2^ADDR_W word window.
  always_comb begin
    addr_err = (lat_addr[1:0] != 2'b00) | (|lat_addr[31:ADDR_W+2]);
  end

  // Sequencer FSM. It updates the latched command, the grant history and the
  // registered responses. A reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_id     <= 1'b0;
      last_grant <= 1'b1;
      core_ack   <= 1'b0;
      core_err   <= 1'b0;
      core_rdata <= '0;
      dma_ack    <= 1'b0;
      dma_err    <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      core_ack <= 1'b0;
      core_err <= 1'b0;
      dma_ack  <= 1'b0;
      dma_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (core_req || dma_req) begin
            lat_we     <= sel_we;
            lat_addr   <= sel_addr;
            lat_wdata  <= sel_wdata;
            lat_id     <= pick_dma;
            last_grant <= pick_dma;
            state      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // The response is registered here so that it appears during DONE.
          state <= ST_DONE;
          if (lat_id) begin
            dma_ack <= 1'b1;
            dma_err <= addr_err;
            if (addr_err) begin
              dma_rdata <= '0;
            end else if (!lat_we) begin
              dma_rdata <= mem_read_data;
            end
          end else begin
            core_ack <= 1'b1;
            core_err <= addr_err;
            if (addr_err) begin
              core_rdata <= '0;
            end else if (!lat_we) begin
              core_rdata <= mem_read_data;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory drive. It comes combinationally from the latched command. The
  // write strobe is gated by rst_n so that a reset during ACCESS cannot
  // commit a write.
  always_comb begin
    mem_address    = '0;
    mem_write_data = '0;
    if (state != ST_IDLE) begin
      mem_address    = lat_addr;
      mem_write_data = lat_wdata;
    end
    mem_read  = (state == ST_ACCESS) & ~lat_we & ~addr_err;
    mem_write = (state == ST_ACCESS) &  lat_we & ~addr_err & rst_n;
  end

  // Status outputs.
  always_comb begin
    busy      = (state != ST_IDLE);
    grant_id  = lat_id;
    state_dbg = state;
  end

  // The two acks are mutually exclusive, and an ack only appears in DONE.
  ack_onehot_a : assert property (@(posedge clk) disable iff (!rst_n)
    !(core_ack && dma_ack));
  ack_in_done_a : assert property (@(posedge clk) disable iff (!rst_n)
    (core_ack || dma_ack) |-> (state == ST_DONE));

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter.
// The memory model here is the environment's memory. A separate reference
// image (ref_mem) and the per-requester rdata expectations predict the
// responses. Expected responses {id, err, rdata} are queued when a request is
// driven. They are popped and compared on every ack.

module tb_data_mem_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int WORDS  = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              core_req, core_we;
  logic [31:0]       core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_ack, core_err;
  logic [DATA_W-1:0] core_rdata;
  logic              dma_req, dma_we;
  logic [31:0]       dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_ack, dma_err;
  logic [DATA_W-1:0] dma_rdata;
  logic              mem_read, mem_write;
  logic [31:0]       mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;
  logic              busy, grant_id;
  logic [1:0]        state_dbg;

  data_mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ack(core_ack), .core_err(core_err), .core_rdata(core_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_err(dma_err), .dma_rdata(dma_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .busy(busy), .grant_id(grant_id), .state_dbg(state_dbg)
  );

  // ---------------- environment memory ----------------
  logic [DATA_W-1:0] ram [0:WORDS-1];
  assign mem_read_data = ram[mem_address[ADDR_W+1:2]];
  always @(posedge clk) if (mem_write) ram[mem_address[ADDR_W+1:2]] <= mem_write_data;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] ref_mem [0:WORDS-1];
  logic [DATA_W-1:0] exp_rd  [0:1];
  logic [DATA_W+1:0] exp_q[$];          // {id, err, rdata}
  int n_checks = 0;
  int n_fail   = 0;
  int wr_pulses = 0, rd_pulses = 0, dma_ack_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void push_exp(input bit id, input bit we,
                                   input logic [31:0] addr, input logic [DATA_W-1:0] wdata);
    bit err;
    err = (addr[1:0] != 2'b00) || (addr[31:ADDR_W+2] != '0);
    if (err)     exp_rd[id] = '0;
    else if (we) ref_mem[addr[ADDR_W+1:2]] = wdata;
    else         exp_rd[id] = ref_mem[addr[ADDR_W+1:2]];
    exp_q.push_back({id, err, exp_rd[id]});
  endfunction

  logic [DATA_W+1:0] mon_e, mon_obs;

  // The monitor counts memory strobes and compares every ack against the queue.
  always @(negedge clk) begin
    if (mem_write) wr_pulses++;
    if (mem_read)  rd_pulses++;
    if (dma_ack)   dma_ack_cnt++;
    if (core_ack || dma_ack) begin
      check("ack_onehot", core_ack & dma_ack, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_ack", {core_ack, dma_ack}, 2'b00);
      end else begin
        mon_e   = exp_q.pop_front();
        mon_obs = dma_ack ? {1'b1, dma_err, dma_rdata} : {1'b0, core_err, core_rdata};
        check("ack_id_err_rdata", mon_obs, mon_e);
        check("grant_id", grant_id, mon_e[DATA_W+1]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0; core_req = 1'b0; dma_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", state_dbg, 2'd0);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_acks", {core_ack, dma_ack, core_err, dma_err}, 4'b0);
    check("rst_core_rdata", core_rdata, 0);
    check("rst_dma_rdata", dma_rdata, 0);
    check("rst_mem_strobes", {mem_read, mem_write}, 2'b00);
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    rst_n = 1'b1;
  endtask

  task automatic txn(input bit id, input bit we, input logic [31:0] addr,
                     input logic [DATA_W-1:0] wdata);
    bit got;
    got = 1'b0;
    @(negedge clk);
    push_exp(id, we, addr, wdata);
    if (id) begin
      dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
    end else begin
      core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = id ? dma_ack : core_ack;
    end
    if (!got) check("ack_timeout", got, 1'b1);
    core_req = 1'b0;
    dma_req  = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w0, r0, d0, acks, last_c, low;
    rst_n = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    dma_req  = 1'b0; dma_we  = 1'b0; dma_addr  = '0; dma_wdata  = '0;
    for (int i = 0; i < WORDS; i++) begin
      ram[i]     = 32'h1000_0000 + i;
      ref_mem[i] = 32'h1000_0000 + i;
    end
    do_reset();

    // 1: core write then read back
    w0 = wr_pulses;
    txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    check("t1_write_pulses", wr_pulses - w0, 1);
    r0 = rd_pulses;
    txn(0, 1'b0, 32'h10, '0);
    check("t1_read_pulses", rd_pulses - r0, 1);

    // 2: simultaneous held requests, four grants
    do_reset();
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40;
    dma_req  = 1'b1; dma_we  = 1'b0; dma_addr  = 32'h10;
`ifdef ARB_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) push_exp(0, 1'b0, 32'h40, '0);
`else
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push_exp(0, 1'b0, 32'h40, '0);
      else            push_exp(1, 1'b0, 32'h10, '0);
    end
`endif
    acks = 0;
    for (int i = 0; i < 40 && acks < 4; i++) begin
      @(negedge clk);
      if (core_ack || dma_ack) acks++;
    end
    core_req = 1'b0; dma_req = 1'b0;
    check("t2_acks", acks, 4);

    // 3: out-of-range DMA read and misaligned core write
    w0 = wr_pulses; r0 = rd_pulses;
    txn(1, 1'b0, 32'h0000_1000, '0);
    txn(0, 1'b1, 32'h6, 32'h5555_5555);
    check("t3_no_strobes", {wr_pulses - w0, rd_pulses - r0}, 0);
    check("t3_dma_rdata", dma_rdata, 0);

    // 4: reset for one cycle during ACCESS of a core write
    txn(0, 1'b1, 32'h20, 32'h1111_1111);
    w0 = wr_pulses;
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h20; core_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    check("t4_in_access", state_dbg, 2'd1);
    rst_n = 1'b0; core_req = 1'b0;
    @(negedge clk);
    check("t4_write_gated", mem_write, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    @(negedge clk);
    check("t4_idle", {state_dbg, busy, core_ack}, 4'b0);
    check("t4_mem8", ram[8], 32'h1111_1111);
    check("t4_write_count", wr_pulses - w0, 0);
    repeat (3) @(negedge clk);
    txn(0, 1'b0, 32'h20, '0);

    // 5: core read held continuously
    d0 = dma_ack_cnt;
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40;
    for (int k = 0; k < 4; k++) push_exp(0, 1'b0, 32'h40, '0);
    acks = 0; last_c = 0; low = 0;
    for (int i = 0; i < 40 && acks < 4; i++) begin
      @(negedge clk);
      if (acks > 0 && !busy) low++;
      if (core_ack) begin
        if (acks > 0) check("t5_ack_spacing", cyc - last_c, 3);
        last_c = cyc;
        acks++;
      end
    end
    core_req = 1'b0;
    check("t5_acks", acks, 4);
    check("t5_busy_low", low, 3);
    check("t5_dma_ack", dma_ack_cnt - d0, 0);

    // random single-requester traffic, mostly legal addresses
    for (int n = 0; n < 12; n++) begin
      logic [31:0] a;
      a = {20'h0, 10'($urandom_range(0, WORDS - 1)), 2'b00};
      if ($urandom_range(0, 5) == 0) a[0] = 1'b1;
      if ($urandom_range(0, 7) == 0) a[20] = 1'b1;
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
    end

    repeat (5) @(negedge clk);
    check("sb_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
